// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: mem_system read port, redirect input and decode handshake.
// master is the fetch unit's view; slave is the memory/decode/execute side.
interface fetch_unit_if;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_data_valid;

    logic        redirect_en;
    logic [31:0] redirect_pc;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output mem_en,
        output mem_wr,
        output mem_addr,
        output mem_data_in,
        input  mem_data_out,
        input  mem_data_valid,
        input  redirect_en,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  mem_en,
        input  mem_wr,
        input  mem_addr,
        input  mem_data_in,
        output mem_data_out,
        output mem_data_valid,
        output redirect_en,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word read to mem_system, results buffered with
// their PCs in a small FIFO for decode; redirect flushes the FIFO and drops any read in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_2000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {REQ, WAIT} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      req_pc_reg, req_pc_next;
    logic             drop_reg, drop_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];

    logic room;
    logic req;
    logic push;
    logic pop;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};

    always_comb begin
        // Room uses the registered count only, so a same-cycle pop never frees a slot.
        room = count_reg < DEPTH_CNT;
        req  = !rst && (state_reg == REQ) && room && !bus.redirect_en;
        push = (state_reg == WAIT) && bus.mem_data_valid && !drop_reg && !bus.redirect_en;
        pop  = bus.if_valid && bus.if_ready && !bus.redirect_en;

        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        drop_next   = drop_reg;

        case (state_reg)
            REQ: begin
                if (req) begin
                    state_next  = WAIT;
                    req_pc_next = pc_reg;
                end
            end
            WAIT: begin
                if (bus.mem_data_valid) begin
                    state_next = REQ;
                    drop_next  = 1'b0;
                end else if (bus.redirect_en) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = REQ;
        endcase

        if (bus.redirect_en) begin
            pc_next = {bus.redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_next = pc_reg + 32'd4;
        end

        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (bus.redirect_en) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= REQ;
            pc_reg     <= RESET_PC;
            req_pc_reg <= RESET_PC;
            drop_reg   <= 1'b0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_pc_reg <= req_pc_next;
            drop_reg   <= drop_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage needs no reset: count_reg alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem[wr_ptr_reg] <= bus.mem_data_out;
            pc_mem[wr_ptr_reg]    <= req_pc_reg;
        end
    end

    assign bus.mem_en      = req;
    assign bus.mem_wr      = 1'b0;
    assign bus.mem_addr    = pc_reg;
    assign bus.mem_data_in = 32'h0;

    assign bus.if_valid = !rst && (count_reg != '0);
    assign bus.if_instr = instr_mem[rd_ptr_reg];
    assign bus.if_pc    = pc_mem[rd_ptr_reg];
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a vector table for the reset/stream/backpressure trace, then
// hand-written redirect and reset corner cases; decode pops are checked against a scoreboard.
module tb_fetch_unit;
    logic clk;
    logic rst;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC  (32'h0000_2000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        exp_en;
        logic        exp_valid;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    localparam int NV = 21;

    vec_t        vecs [NV];
    exp_t        sb_q [$];
    int          n_checks;
    int          n_fail;
    int          lat;
    int          pending;
    logic [31:0] pend_addr;
    logic        got;
    logic        hit;
    logic        dv;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic en, input logic vld,
                                input logic ca, input logic [31:0] a, input logic [31:0] p);
        vec_t v;
        v.rst = r; v.ready = rdy; v.exp_en = en; v.exp_valid = vld;
        v.chk_addr = ca; v.exp_addr = a; v.exp_pc = p;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = rom_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Memory model: a request seen in cycle N returns data in cycle N+lat.
    task automatic mem_drive();
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out   = 32'h0;
        if (pending > 0) begin
            pending--;
            if (pending == 0) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_out   = rom_word(pend_addr);
            end
        end
    endtask

    task automatic prepare();
        mem_drive();
        #1;
    endtask

    task automatic end_cycle();
        exp_t e;
        if (bus.mem_en) begin
            check32("mem_one_outstanding", 32'(pending), 32'd0);
            pending   = lat;
            pend_addr = bus.mem_addr;
        end
        if (bus.if_valid && bus.if_ready && !bus.redirect_en && !rst) begin
            $display("pop pc=%h instr=%h", bus.if_pc, bus.if_instr);
            if (sb_q.size() == 0) begin
                check32("unexpected_pop_pc", bus.if_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check32("pop_pc", bus.if_pc, e.pc);
                check32("pop_instr", bus.if_instr, e.instr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        bus.if_ready = 1'b1;
        for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
            prepare();
            end_cycle();
        end
        check32(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        lat      = 1;
        pending  = 0;
        pend_addr = 32'h0;
        rst = 1'b1;
        bus.if_ready       = 1'b0;
        bus.redirect_en    = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out   = 32'h0;

        // Reset, stream with 1-cycle memory, reset, then backpressure and release.
        vecs[0]  = mk(1, 0, 0, 0, 1, 32'h2000, 32'h0);
        vecs[1]  = mk(1, 0, 0, 0, 1, 32'h2000, 32'h0);
        vecs[2]  = mk(0, 1, 1, 0, 1, 32'h2000, 32'h0);
        vecs[3]  = mk(0, 1, 0, 0, 1, 32'h2000, 32'h0);
        vecs[4]  = mk(0, 1, 1, 1, 1, 32'h2004, 32'h2000);
        vecs[5]  = mk(0, 1, 0, 0, 1, 32'h2004, 32'h0);
        vecs[6]  = mk(0, 1, 1, 1, 1, 32'h2008, 32'h2004);
        vecs[7]  = mk(0, 1, 0, 0, 1, 32'h2008, 32'h0);
        vecs[8]  = mk(0, 1, 1, 1, 1, 32'h200C, 32'h2008);
        vecs[9]  = mk(1, 0, 0, 0, 0, 32'h0,    32'h0);
        vecs[10] = mk(1, 0, 0, 0, 1, 32'h2000, 32'h0);
        vecs[11] = mk(0, 0, 1, 0, 1, 32'h2000, 32'h0);
        vecs[12] = mk(0, 0, 0, 0, 1, 32'h2000, 32'h0);
        vecs[13] = mk(0, 0, 1, 1, 1, 32'h2004, 32'h2000);
        vecs[14] = mk(0, 0, 0, 1, 1, 32'h2004, 32'h2000);
        vecs[15] = mk(0, 0, 0, 1, 1, 32'h2008, 32'h2000);
        vecs[16] = mk(0, 0, 0, 1, 1, 32'h2008, 32'h2000);
        vecs[17] = mk(0, 1, 0, 1, 1, 32'h2008, 32'h2000);
        vecs[18] = mk(0, 1, 1, 1, 1, 32'h2008, 32'h2004);
        vecs[19] = mk(0, 1, 0, 0, 1, 32'h2008, 32'h0);
        vecs[20] = mk(0, 1, 1, 1, 1, 32'h200C, 32'h2008);

        push_exp(32'h2000); push_exp(32'h2004); push_exp(32'h2008);
        push_exp(32'h2000); push_exp(32'h2004); push_exp(32'h2008);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            bus.if_ready = vecs[i].ready;
            prepare();
            check1($sformatf("vec%0d_mem_en", i), bus.mem_en, vecs[i].exp_en);
            check1($sformatf("vec%0d_if_valid", i), bus.if_valid, vecs[i].exp_valid);
            if (vecs[i].chk_addr)
                check32($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                check32($sformatf("vec%0d_if_pc", i), bus.if_pc, vecs[i].exp_pc);
                check32($sformatf("vec%0d_if_instr", i), bus.if_instr, rom_word(vecs[i].exp_pc));
            end
            end_cycle();
        end
        check32("table_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect one cycle after a request to 0x2008, 4-cycle memory.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin prepare(); end_cycle(); end
        rst = 1'b0;
        lat = 4;
        bus.if_ready = 1'b1;
        push_exp(32'h2000); push_exp(32'h2004);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prepare();
            hit = bus.mem_en && (bus.mem_addr == 32'h2008);
            end_cycle();
            if (hit) begin got = 1'b1; break; end
        end
        check1("A_req_2008_seen", got, 1'b1);
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h2103;
        prepare();
        check1("A_redir_no_req", bus.mem_en, 1'b0);
        end_cycle();
        bus.redirect_en = 1'b0;
        check32("A_sb_before", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        push_exp(32'h2100);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            prepare();
            dv = bus.mem_data_valid;
            check1("A_hold_en", bus.mem_en, 1'b0);
            check1("A_fifo_empty", bus.if_valid, 1'b0);
            check32("A_addr_target", bus.mem_addr, 32'h2100);
            end_cycle();
            if (dv) begin got = 1'b1; break; end
        end
        check1("A_dropped_data_returned", got, 1'b1);
        prepare();
        check1("A_req_en", bus.mem_en, 1'b1);
        check32("A_req_addr", bus.mem_addr, 32'h2100);
        end_cycle();

        // Redirect in the same cycle that the 0x2100 data returns.
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_drive();
            if (bus.mem_data_valid) begin
                bus.redirect_en = 1'b1;
                bus.redirect_pc = 32'h3000;
            end
            #1;
            dv = bus.mem_data_valid;
            end_cycle();
            bus.redirect_en = 1'b0;
            if (dv) begin got = 1'b1; break; end
        end
        check1("B_coincident_seen", got, 1'b1);
        sb_q.delete();
        push_exp(32'h3000);
        prepare();
        check1("B_req_en", bus.mem_en, 1'b1);
        check32("B_req_addr", bus.mem_addr, 32'h3000);
        check1("B_no_push", bus.if_valid, 1'b0);
        end_cycle();
        drain("B_drain", 30);

        // Fill the FIFO under backpressure, then redirect with a pop attempt.
        bus.if_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin prepare(); end_cycle(); end
        prepare();
        check1("C_full_valid", bus.if_valid, 1'b1);
        check1("C_full_no_req", bus.mem_en, 1'b0);
        check32("C_head_pc", bus.if_pc, 32'h3004);
        end_cycle();
        mem_drive();
        bus.if_ready    = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h4000;
        #1;
        check1("C_redir_no_req", bus.mem_en, 1'b0);
        end_cycle();
        bus.redirect_en = 1'b0;
        sb_q.delete();
        push_exp(32'h4000);
        lat = 3;
        prepare();
        check1("C_flushed", bus.if_valid, 1'b0);
        check32("C_pc_target", bus.mem_addr, 32'h4000);
        check1("C_req_en", bus.mem_en, 1'b1);
        end_cycle();
        drain("C_drain", 30);

        // Reset while a 3-cycle read is outstanding; stale data returns after reset.
        bus.if_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prepare();
            hit = bus.mem_en;
            end_cycle();
            if (hit) begin got = 1'b1; break; end
        end
        check1("D_req_seen", got, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prepare();
            check1("D_rst_no_req", bus.mem_en, 1'b0);
            check1("D_rst_no_valid", bus.if_valid, 1'b0);
            end_cycle();
        end
        rst = 1'b0;
        sb_q.delete();
        push_exp(32'h2000); push_exp(32'h2004);
        prepare();
        check1("D_first_en", bus.mem_en, 1'b1);
        check32("D_first_addr", bus.mem_addr, 32'h2000);
        end_cycle();
        drain("D_drain", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits between the program counter and `mem_system`. It issues word-aligned read requests to `mem_system` and tolerates variable read latency by waiting for `data_valid`. Returned instructions are buffered with their PCs in a small FIFO and presented to decode over a valid/ready handshake. A redirect input supports branches and jumps: it flushes buffered instructions and discards any read still in flight.

## Interface
- `RESET_PC`, default 32'h0000_2000: PC loaded on reset; the start of the ROM image window.
- `FIFO_DEPTH`, default 2: instruction buffer entries; a power of two, at least 2.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_en`  out  1  read request strobe to `mem_system`.
- `mem_wr`  out  1  tied to 0.
- `mem_addr`  out  32  request address; always equals the PC register.
- `mem_data_in`  out  32  tied to 0.
- `mem_data_out`  in  32  read data from `mem_system`.
- `mem_data_valid`  in  1  read data valid; sampled only in WAIT.
- `redirect_en`  in  1  one-cycle redirect pulse from execute.
- `redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0.
- `if_valid`  out  1  FIFO head is valid.
- `if_ready`  in  1  decode accepts the head.
- `if_instr`  out  32  instruction at the FIFO head.
- `if_pc`  out  32  PC of the FIFO head.

## Operation
- State registers:
  - `pc` (32 bits).
  - `state` ∈ {REQ, WAIT}.
  - `drop` (1 bit).
  - FIFO with `count` ∈ 0..FIFO_DEPTH, plus read and write pointers that wrap modulo FIFO_DEPTH.
- Room condition: `count < FIFO_DEPTH`, evaluated on the registered `count` only. A pop in the same cycle does not create room.
- REQ state:
  - Request: `mem_en = room && !redirect_en`.
  - When `mem_en` is 1, the request PC is latched into `req_pc` and the state moves to WAIT.
  - With no room, the block stays in REQ with `mem_en` = 0.
- WAIT state:
  - `mem_en` = 0.
  - When `mem_data_valid` is 1 and `drop` is 0, the FIFO pushes {`req_pc`, `mem_data_out`} and `pc` <= `pc` + 4 (wraps mod 2^32).
  - When `mem_data_valid` is 1 and `drop` is 1, the data is discarded and `drop` <= 0.
  - Either way, on `mem_data_valid` the state moves to REQ.
- Redirect (`redirect_en` = 1) has top priority:
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - FIFO flushed: `count` <= 0 and pointers reset. A same-cycle pop and any same-cycle push are suppressed.
  - In REQ: no request is issued that cycle; the state stays REQ.
  - In WAIT with `mem_data_valid` = 0: `drop` <= 1; the state stays WAIT.
  - In WAIT with `mem_data_valid` = 1: the data is discarded, `drop` stays 0, and the state moves to REQ.
  - In WAIT with `drop` already 1: `pc` is updated and `drop` stays 1.
- Decode handshake:
  - A pop happens when `if_valid && if_ready`.
  - `if_instr` and `if_pc` show the head entry combinationally from FIFO storage. They hold steady while `if_valid && !if_ready`.
  - `if_valid = (count != 0)`.
  - Push and pop in the same cycle leave `count` unchanged.
- Memory contract: at most one request outstanding. Data is returned exactly once per request, after at least one cycle.

## Timing
- Values during and immediately after reset:
  - `pc` = RESET_PC, `state` = REQ, `drop` = 0, `count` = 0.
  - `if_valid` = 0 and `mem_en` = 0 while `rst` is high.
  - `mem_addr` = RESET_PC.
- Fetch pipeline:
  - `mem_en` first asserts in the first cycle after `rst` falls.
  - With 1-cycle memory:
    - Request in cycle N.
    - `mem_data_valid` in N+1.
    - `if_valid` in N+2.
    - Next request in N+2.
  - Steady-state throughput is one instruction per 2 cycles; per-request latency is 2 cycles plus any extra memory latency.
- Reset mid-operation (including during WAIT):
  - Outstanding data is ignored because `state` returns to REQ with `drop` = 0.
  - A late `mem_data_valid` arriving in REQ is ignored.
- Redirect timing:
  - The first request to the target issues in the cycle after the `redirect_en` pulse, if no read is outstanding.
  - If a read was outstanding, the target request issues in the cycle after the dropped data returns.

## Test plan
- Reset then stream:
  - Stimulus: 1-cycle memory, `if_ready` = 1.
  - Response: `if_pc` sequence 0x2000, 0x2004, 0x2008 with matching ROM words, one every 2 cycles; first `if_valid` 2 cycles after the first `mem_en`.
- Backpressure:
  - Stimulus: `if_ready` = 0.
  - Response: `count` reaches 2 and `mem_en` stays 0. `if_pc` holds 0x2000 with `if_instr` steady. Once `if_ready` goes to 1, 0x2000 then 0x2004 are consumed in order and fetch resumes at 0x2008.
- Redirect during WAIT:
  - Stimulus: 4-cycle memory; `redirect_en` with `redirect_pc` = 0x2103 one cycle after a request to 0x2008.
  - Response: the 0x2008 data is discarded, the FIFO is empty, and the next `mem_addr` = 0x2100 with `mem_en` the cycle after the data returns.
- Redirect coincident with `mem_data_valid`:
  - Response: no push and `drop` stays 0. A request to the target issues on the next cycle.
- Redirect with a full FIFO and a simultaneous pop:
  - Response: `count` = 0 next cycle, `if_valid` = 0, `pc` = target.
- Reset mid-WAIT:
  - Stimulus: `rst` pulsed while a 3-cycle read is outstanding; the stale `mem_data_valid` arrives afterward.
  - Response: the stale data is never pushed, and the first fetch after reset is from 0x2000.
